// File: rtl/controlador_semaforo.sv
// Phase timing controller for the two-street traffic light: tracks the light phase,
// times green/yellow, latches vehicle requests and emits a one-cycle advance strobe.
module controlador_semaforo #(
  parameter int T_VERDE_MIN = 10,
  parameter int T_VERDE_MAX = 30,
  parameter int T_AMARELO   = 4,
  parameter int W           = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         habilita,
  input  logic         sensor_rua_1,
  input  logic         sensor_rua_2,
  input  logic         modo_manual,
  input  logic         botao,
  output logic         pulso,
  output logic [1:0]   fase,
  output logic [W-1:0] contador,
  output logic [1:0]   pedido_pendente
);

  localparam logic [1:0] F_R2_VERDE   = 2'b00;
  localparam logic [1:0] F_R2_AMARELO = 2'b01;
  localparam logic [1:0] F_R1_VERDE   = 2'b10;
  localparam logic [1:0] F_R1_AMARELO = 2'b11;

  localparam logic [W-1:0] C_VERDE_MAX = W'(T_VERDE_MAX - 1);
  localparam logic [W-1:0] C_VERDE_MIN = W'(T_VERDE_MIN - 1);
  localparam logic [W-1:0] C_AMARELO   = W'(T_AMARELO - 1);
  localparam logic [W-1:0] C_SATURADO  = {W{1'b1}};

  logic [1:0]   fase_r;
  logic [W-1:0] contador_r;
  logic         pulso_r;
  logic [1:0]   req_r;
  logic         botao_prev_r;

  logic         avanco_s;
  logic [1:0]   fase_prox_s;
  logic [W-1:0] contador_prox_s;
  logic [1:0]   req_prox_s;

  // Advance decision: button edge in manual mode, phase timers in auto mode
  always_comb begin
    avanco_s = 1'b0;
    if (modo_manual) begin
      avanco_s = botao & ~botao_prev_r;
    end else if (habilita) begin
      case (fase_r)
        F_R2_VERDE:   avanco_s = (contador_r == C_VERDE_MAX) ||
                                 ((contador_r >= C_VERDE_MIN) && req_r[0]);
        F_R1_VERDE:   avanco_s = (contador_r == C_VERDE_MAX) ||
                                 ((contador_r >= C_VERDE_MIN) && req_r[1]);
        F_R2_AMARELO: avanco_s = (contador_r == C_AMARELO);
        F_R1_AMARELO: avanco_s = (contador_r == C_AMARELO);
        default:      avanco_s = 1'b0;
      endcase
    end else begin
      avanco_s = 1'b0;
    end
  end

  // Next phase and elapsed-cycle counter; manual mode pins the counter at zero
  always_comb begin
    fase_prox_s     = fase_r;
    contador_prox_s = contador_r;
    if (avanco_s) begin
      fase_prox_s     = fase_r + 2'd1;
      contador_prox_s = '0;
    end else if (modo_manual) begin
      contador_prox_s = '0;
    end else if (habilita && (contador_r != C_SATURADO)) begin
      contador_prox_s = contador_r + W'(1);
    end else begin
      contador_prox_s = contador_r;
    end
  end

  // Request latches: a street's request clears as its green starts, and clear beats set
  always_comb begin
    req_prox_s = req_r;
    if (avanco_s && (fase_prox_s == F_R1_VERDE)) begin
      req_prox_s[0] = 1'b0;
    end else if (sensor_rua_1 && !fase_r[1]) begin
      req_prox_s[0] = 1'b1;
    end else begin
      req_prox_s[0] = req_r[0];
    end
    if (avanco_s && (fase_prox_s == F_R2_VERDE)) begin
      req_prox_s[1] = 1'b0;
    end else if (sensor_rua_2 && fase_r[1]) begin
      req_prox_s[1] = 1'b1;
    end else begin
      req_prox_s[1] = req_r[1];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fase_r       <= F_R2_VERDE;
      contador_r   <= '0;
      pulso_r      <= 1'b0;
      req_r        <= 2'b00;
      botao_prev_r <= 1'b0;
    end else begin
      fase_r       <= fase_prox_s;
      contador_r   <= contador_prox_s;
      pulso_r      <= avanco_s;
      req_r        <= req_prox_s;
      botao_prev_r <= botao;
    end
  end

  assign pulso           = pulso_r;
  assign fase            = fase_r;
  assign contador        = contador_r;
  assign pedido_pendente = req_r;

endmodule

// File: tb/tb_controlador_semaforo.sv
// Directed, table-driven bench for controlador_semaforo with hand-computed expectations
// plus hand-written multi-cycle sequences for the full cycle and phase timing.
module tb_controlador_semaforo;

  logic       clk = 1'b0;
  logic       rst, habilita, sensor_rua_1, sensor_rua_2, modo_manual, botao;
  logic       pulso;
  logic [1:0] fase;
  logic [7:0] contador;
  logic [1:0] pedido_pendente;

  int n_cmp = 0;
  int n_bad = 0;

  controlador_semaforo #(.T_VERDE_MIN(10), .T_VERDE_MAX(30), .T_AMARELO(4), .W(8)) dut (
    .clk(clk), .rst(rst), .habilita(habilita), .sensor_rua_1(sensor_rua_1),
    .sensor_rua_2(sensor_rua_2), .modo_manual(modo_manual), .botao(botao),
    .pulso(pulso), .fase(fase), .contador(contador), .pedido_pendente(pedido_pendente)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, hab, s1, s2, man, bot;
    int         n;
    logic [1:0] fase;
    logic [7:0] cnt;
    logic       pul;
    logic [1:0] req;
  } vec_t;

  vec_t v[44];

  function automatic vec_t mk(logic r, logic h, logic a, logic b, logic m, logic bt, int n,
                              logic [1:0] f, logic [7:0] c, logic p, logic [1:0] q);
    vec_t x;
    x.rst = r; x.hab = h; x.s1 = a; x.s2 = b; x.man = m; x.bot = bt; x.n = n;
    x.fase = f; x.cnt = c; x.pul = p; x.req = q;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int pulses;
  int consec;
  logic prev_p;

  initial begin
    rst = 1'b1; habilita = 1'b1; sensor_rua_1 = 1'b0; sensor_rua_2 = 1'b0;
    modo_manual = 1'b0; botao = 1'b0;

    //      rst  hab  s1   s2   man  bot  n   fase   cnt   pul  req
    v[0]  = mk(1, 1, 0, 0, 0, 0,  1, 2'd0, 8'd0,  1'b0, 2'b00);
    v[1]  = mk(0, 1, 0, 0, 0, 0, 29, 2'd0, 8'd29, 1'b0, 2'b00);
    v[2]  = mk(0, 1, 0, 0, 0, 0,  1, 2'd1, 8'd0,  1'b1, 2'b00);
    v[3]  = mk(0, 1, 0, 0, 0, 0,  1, 2'd1, 8'd1,  1'b0, 2'b00);
    v[4]  = mk(0, 1, 0, 0, 0, 0,  2, 2'd1, 8'd3,  1'b0, 2'b00);
    v[5]  = mk(0, 1, 0, 0, 0, 0,  1, 2'd2, 8'd0,  1'b1, 2'b00);
    v[6]  = mk(0, 1, 0, 1, 0, 0,  1, 2'd2, 8'd1,  1'b0, 2'b10);
    v[7]  = mk(0, 1, 0, 0, 0, 0,  8, 2'd2, 8'd9,  1'b0, 2'b10);
    v[8]  = mk(0, 1, 0, 0, 0, 0,  1, 2'd3, 8'd0,  1'b1, 2'b10);
    v[9]  = mk(0, 1, 0, 0, 0, 0,  3, 2'd3, 8'd3,  1'b0, 2'b10);
    v[10] = mk(0, 1, 0, 0, 0, 0,  1, 2'd0, 8'd0,  1'b1, 2'b00);
    v[11] = mk(0, 1, 0, 0, 0, 0,  3, 2'd0, 8'd3,  1'b0, 2'b00);
    v[12] = mk(0, 1, 1, 0, 0, 0,  1, 2'd0, 8'd4,  1'b0, 2'b01);
    v[13] = mk(0, 1, 0, 0, 0, 0,  5, 2'd0, 8'd9,  1'b0, 2'b01);
    v[14] = mk(0, 1, 0, 0, 0, 0,  1, 2'd1, 8'd0,  1'b1, 2'b01);
    v[15] = mk(0, 1, 0, 0, 0, 0,  3, 2'd1, 8'd3,  1'b0, 2'b01);
    v[16] = mk(0, 1, 0, 0, 0, 0,  1, 2'd2, 8'd0,  1'b1, 2'b00);
    v[17] = mk(0, 1, 0, 0, 0, 0, 12, 2'd2, 8'd12, 1'b0, 2'b00);
    v[18] = mk(0, 0, 0, 0, 0, 0,  7, 2'd2, 8'd12, 1'b0, 2'b00);
    v[19] = mk(0, 1, 0, 0, 0, 0, 17, 2'd2, 8'd29, 1'b0, 2'b00);
    v[20] = mk(0, 1, 0, 0, 0, 0,  1, 2'd3, 8'd0,  1'b1, 2'b00);
    v[21] = mk(0, 1, 0, 0, 0, 0,  3, 2'd3, 8'd3,  1'b0, 2'b00);
    v[22] = mk(0, 1, 0, 0, 0, 0,  1, 2'd0, 8'd0,  1'b1, 2'b00);
    v[23] = mk(0, 1, 0, 1, 0, 0, 29, 2'd0, 8'd29, 1'b0, 2'b00);
    v[24] = mk(0, 1, 0, 1, 0, 0,  1, 2'd1, 8'd0,  1'b1, 2'b00);
    v[25] = mk(0, 1, 0, 0, 0, 0,  2, 2'd1, 8'd2,  1'b0, 2'b00);
    v[26] = mk(0, 1, 0, 0, 1, 0,  1, 2'd1, 8'd0,  1'b0, 2'b00);
    v[27] = mk(0, 1, 0, 0, 1, 1,  1, 2'd2, 8'd0,  1'b1, 2'b00);
    v[28] = mk(0, 1, 0, 0, 1, 1,  4, 2'd2, 8'd0,  1'b0, 2'b00);
    v[29] = mk(0, 1, 0, 0, 1, 0,  1, 2'd2, 8'd0,  1'b0, 2'b00);
    v[30] = mk(0, 1, 0, 0, 1, 1,  1, 2'd3, 8'd0,  1'b1, 2'b00);
    v[31] = mk(0, 0, 0, 0, 1, 0,  1, 2'd3, 8'd0,  1'b0, 2'b00);
    v[32] = mk(0, 0, 0, 0, 1, 1,  1, 2'd0, 8'd0,  1'b1, 2'b00);
    v[33] = mk(0, 1, 0, 0, 1, 0,  1, 2'd0, 8'd0,  1'b0, 2'b00);
    v[34] = mk(0, 1, 0, 0, 0, 0, 29, 2'd0, 8'd29, 1'b0, 2'b00);
    v[35] = mk(0, 1, 0, 0, 0, 0,  1, 2'd1, 8'd0,  1'b1, 2'b00);
    v[36] = mk(0, 1, 0, 0, 0, 0,  3, 2'd1, 8'd3,  1'b0, 2'b00);
    v[37] = mk(0, 1, 0, 0, 0, 0,  1, 2'd2, 8'd0,  1'b1, 2'b00);
    v[38] = mk(0, 1, 0, 0, 0, 0, 29, 2'd2, 8'd29, 1'b0, 2'b00);
    v[39] = mk(0, 1, 0, 0, 0, 0,  1, 2'd3, 8'd0,  1'b1, 2'b00);
    v[40] = mk(0, 1, 0, 1, 0, 0,  1, 2'd3, 8'd1,  1'b0, 2'b10);
    v[41] = mk(1, 1, 0, 0, 0, 0,  1, 2'd0, 8'd0,  1'b0, 2'b00);
    v[42] = mk(1, 1, 1, 1, 1, 1,  2, 2'd0, 8'd0,  1'b0, 2'b00);
    v[43] = mk(0, 1, 0, 0, 0, 0,  1, 2'd0, 8'd1,  1'b0, 2'b00);

    for (int i = 0; i < 44; i++) begin
      rst = v[i].rst; habilita = v[i].hab; sensor_rua_1 = v[i].s1;
      sensor_rua_2 = v[i].s2; modo_manual = v[i].man; botao = v[i].bot;
      step(v[i].n);
      check($sformatf("v%0d_fase", i), fase, v[i].fase);
      check($sformatf("v%0d_contador", i), contador, v[i].cnt);
      check($sformatf("v%0d_pulso", i), pulso, v[i].pul);
      check($sformatf("v%0d_pedido", i), pedido_pendente, v[i].req);
    end

    // Full 68-cycle run from reset: contador ramp, pulse count, no back-to-back pulses
    rst = 1'b1; step(1);
    rst = 1'b0; habilita = 1'b1; sensor_rua_1 = 1'b0; sensor_rua_2 = 1'b0;
    modo_manual = 1'b0; botao = 1'b0;
    pulses = 0; consec = 0; prev_p = 1'b0;
    for (int c = 0; c < 68; c++) begin
      if (c < 30) check($sformatf("ramp_c%0d", c), contador, c);
      step(1);
      if (pulso) pulses++;
      if (pulso && prev_p) consec++;
      prev_p = pulso;
    end
    check("cycle_pulses", pulses, 4);
    check("cycle_consecutive", consec, 0);
    check("cycle_fase", fase, 0);
    check("cycle_contador", contador, 0);

    // Late request at contador 20 ends green after 22 cycles
    step(20);
    check("late_pre_cnt", contador, 20);
    sensor_rua_1 = 1'b1; step(1); sensor_rua_1 = 1'b0;
    check("late_req", pedido_pendente, 1);
    step(1);
    check("late_fase", fase, 1);
    check("late_pulso", pulso, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
